// File: rtl/read_counter.sv
// read_counter: CDU read counter accumulating error-angle steps and forwarding them to the AGC
// Ports: CLOCKH clock, rst_n sync active-low reset; _UPLVL/_DNLVL step levels, STEPH step strobe,
// CCDUZ zero command, CTRACK AGC acknowledge; _CNT counter, _DC ladder bits (_CNT[15:4]),
// PCDU/MCDU held increment requests, STALL refused-step flag (all registered).
module read_counter #(
  parameter int PEND_MAX = 7,
  parameter int MIN_GAP  = 2
) (
  input  logic        CLOCKH,
  input  logic        rst_n,
  input  logic        _UPLVL,
  input  logic        _DNLVL,
  input  logic        STEPH,
  input  logic        CCDUZ,
  input  logic        CTRACK,
  output logic [15:0] _CNT,
  output logic [11:0] _DC,
  output logic        PCDU,
  output logic        MCDU,
  output logic        STALL
);
  typedef enum logic [1:0] {IDLE, REQ_P, REQ_M, GAP} state_t;
  localparam logic signed [4:0] PMAX = 5'(PEND_MAX);
  state_t state;
  logic signed [4:0] pend, pend_nx;
  logic [3:0] gap;
  logic up_req, dn_req, up_ok, dn_ok, ack_p, ack_m;
  assign _DC = _CNT[15:4];
  // limit is judged on pend before this cycle's acknowledge adjustment
  always_comb begin
    up_req  = STEPH & _UPLVL & ~_DNLVL;
    dn_req  = STEPH & _DNLVL & ~_UPLVL;
    up_ok   = up_req & (pend != PMAX);
    dn_ok   = dn_req & (pend != -PMAX);
    ack_p   = CTRACK & (state == REQ_P);
    ack_m   = CTRACK & (state == REQ_M);
    pend_nx = pend + 5'(up_ok) - 5'(dn_ok) - 5'(ack_p) + 5'(ack_m);
  end
  always_ff @(posedge CLOCKH) begin
    if (!rst_n || CCDUZ) begin
      _CNT  <= '0;
      pend  <= '0;
      state <= IDLE;
      gap   <= '0;
      PCDU  <= 1'b0;
      MCDU  <= 1'b0;
      STALL <= 1'b0;
    end else begin
      _CNT  <= _CNT + 16'(up_ok) - 16'(dn_ok);
      pend  <= pend_nx;
      STALL <= (up_req & ~up_ok) | (dn_req & ~dn_ok);
      PCDU  <= 1'b0;
      MCDU  <= 1'b0;
      // request direction is latched on entry and held until acknowledged
      case (state)
        IDLE:
          if (pend > 5'sd0) begin
            state <= REQ_P;
            PCDU  <= 1'b1;
          end else if (pend < 5'sd0) begin
            state <= REQ_M;
            MCDU  <= 1'b1;
          end
        REQ_P:
          if (CTRACK) begin
            state <= GAP;
            gap   <= 4'(MIN_GAP - 1);
          end else PCDU <= 1'b1;
        REQ_M:
          if (CTRACK) begin
            state <= GAP;
            gap   <= 4'(MIN_GAP - 1);
          end else MCDU <= 1'b1;
        GAP:
          if (gap == 4'd0) state <= IDLE;
          else gap <= gap - 4'd1;
      endcase
    end
  end
endmodule
